// File: rtl/flt_rdarb_pkg.sv
// Shared types and constants for the filter AXI read-port arbiter.
package flt_rdarb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  localparam logic GNT_S0 = 1'b0;
  localparam logic GNT_S1 = 1'b1;
  localparam int   BEAT_W = 9;
endpackage

// File: rtl/flt_rdarb_rrsel.sv
// Combinational 2-way round-robin pick; ptr names the requester favoured on a tie.
module flt_rdarb_rrsel
  import flt_rdarb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       vld,
  output logic       sel
);
  always_comb begin
    vld = |req;
    sel = GNT_S0;
    if (&req)        sel = ptr;
    else if (req[1]) sel = GNT_S1;
  end
endmodule

// File: rtl/flt_rdarb.sv
// Two-requester burst arbiter for the filter's single AXI read port.
module flt_rdarb
  import flt_rdarb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  ARST,
  input  logic                  RSTS,
  input  logic [ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]            S0_ARLEN,
  input  logic                  S0_ARVALID,
  output logic                  S0_ARREADY,
  output logic [DATA_WIDTH-1:0] S0_RDATA,
  output logic                  S0_RLAST,
  output logic                  S0_RVALID,
  input  logic                  S0_RREADY,
  input  logic [ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]            S1_ARLEN,
  input  logic                  S1_ARVALID,
  output logic                  S1_ARREADY,
  output logic [DATA_WIDTH-1:0] S1_RDATA,
  output logic                  S1_RLAST,
  output logic                  S1_RVALID,
  input  logic                  S1_RREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic                  GNT,
  output logic                  BUSY,
  output logic                  PROTERR
);
  state_t            state;
  logic              gnt, ptr, proterr;
  logic [7:0]        len_q;
  logic [BEAT_W-1:0] cnt, cnt_nx, len_beats;
  logic              pick_vld, pick_sel;
  logic              in_addr, in_data, d0, d1;

  flt_rdarb_rrsel u_rrsel (
    .req ({S1_ARVALID, S0_ARVALID}),
    .ptr (ptr),
    .vld (pick_vld),
    .sel (pick_sel)
  );

  assign in_addr   = (state == ADDR);
  assign in_data   = (state == DATA);
  assign d0        = in_data & (gnt == GNT_S0);
  assign d1        = in_data & (gnt == GNT_S1);
  assign cnt_nx    = cnt + BEAT_W'(1);
  assign len_beats = {1'b0, len_q} + BEAT_W'(1);

  // Address and beats are pure pass-through muxes; only the phase is registered.
  assign ARVALID    = in_addr;
  assign ARADDR     = in_addr ? (gnt ? S1_ARADDR : S0_ARADDR) : '0;
  assign ARLEN      = in_addr ? (gnt ? S1_ARLEN  : S0_ARLEN)  : '0;
  assign S0_ARREADY = in_addr & (gnt == GNT_S0) & ARREADY;
  assign S1_ARREADY = in_addr & (gnt == GNT_S1) & ARREADY;

  assign RREADY    = (d0 & S0_RREADY) | (d1 & S1_RREADY);
  assign S0_RVALID = d0 & RVALID;
  assign S0_RLAST  = d0 & RLAST;
  assign S0_RDATA  = d0 ? RDATA : '0;
  assign S1_RVALID = d1 & RVALID;
  assign S1_RLAST  = d1 & RLAST;
  assign S1_RDATA  = d1 ? RDATA : '0;

  assign GNT     = gnt;
  assign BUSY    = (state != IDLE);
  assign PROTERR = proterr;

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state   <= IDLE;
      gnt     <= GNT_S0;
      ptr     <= GNT_S0;
      proterr <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Soft reset only lands between bursts so no AXI transfer is abandoned.
          if (RSTS) begin
            proterr <= 1'b0;
            ptr     <= GNT_S0;
          end else if (pick_vld) begin
            gnt   <= pick_sel;
            len_q <= pick_sel ? S1_ARLEN : S0_ARLEN;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          if (RVALID && RREADY) begin
            cnt <= cnt_nx;
            if (RLAST) begin
              state <= IDLE;
              ptr   <= ~gnt;
              if (cnt_nx != len_beats) proterr <= 1'b1;
            end else if (cnt_nx == len_beats) begin
              proterr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flt_rdarb.sv
// Directed + randomized bench for flt_rdarb with a burst-level reference model.
module tb_flt_rdarb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0, ARST = 1'b1, RSTS = 1'b0;
  logic [1:0]    s_arvalid = '0, s_rready = '0;
  logic [AW-1:0] s_araddr [2];
  logic [7:0]    s_arlen  [2];
  logic          s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid, rready, gnt, busy, proterr;
  logic          arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;

  logic [1:0]    s_arready, s_rvalid, s_rlast;
  logic [DW-1:0] s_rdata [2];
  assign s_arready = {s1_arready, s0_arready};
  assign s_rvalid  = {s1_rvalid, s0_rvalid};
  assign s_rlast   = {s1_rlast, s0_rlast};
  assign s_rdata[0] = s0_rdata;
  assign s_rdata[1] = s1_rdata;

  int checks = 0;
  int errors = 0;
  // Reference model: who completed a burst last, and whether any burst was mis-sized.
  logic m_last = 1'b1;
  logic m_perr = 1'b0;

  flt_rdarb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .ARST(ARST), .RSTS(RSTS),
    .S0_ARADDR(s_araddr[0]), .S0_ARLEN(s_arlen[0]), .S0_ARVALID(s_arvalid[0]),
    .S0_ARREADY(s0_arready), .S0_RDATA(s0_rdata), .S0_RLAST(s0_rlast),
    .S0_RVALID(s0_rvalid), .S0_RREADY(s_rready[0]),
    .S1_ARADDR(s_araddr[1]), .S1_ARLEN(s_arlen[1]), .S1_ARVALID(s_arvalid[1]),
    .S1_ARREADY(s1_arready), .S1_RDATA(s1_rdata), .S1_RLAST(s1_rlast),
    .S1_RVALID(s1_rvalid), .S1_RREADY(s_rready[1]),
    .ARADDR(araddr), .ARLEN(arlen), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
    .GNT(gnt), .BUSY(busy), .PROTERR(proterr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic winner(input logic [1:0] req);
    if (req == 2'b11) return ~m_last;
    return req[1];
  endfunction

  task automatic all_quiet(input string tag);
    chk({tag, "_arvalid"}, arvalid, 1'b0);
    chk({tag, "_rready"}, rready, 1'b0);
    chk({tag, "_s_arready"}, s_arready, 2'b00);
    chk({tag, "_s_rvalid"}, s_rvalid, 2'b00);
    chk({tag, "_s_rlast"}, s_rlast, 2'b00);
    chk({tag, "_s0_rdata"}, s0_rdata, '0);
    chk({tag, "_s1_rdata"}, s1_rdata, '0);
    chk({tag, "_araddr"}, araddr, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_gnt"}, gnt, 1'b0);
  endtask

  // Called in the low clock phase with the DUT idle; returns the expected winner.
  task automatic request(input logic [1:0] mask, output logic g);
    s_arvalid = mask;
    #1;
    chk("idle_arvalid", arvalid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    g = winner(mask);
    @(posedge CLK);
  endtask

  task automatic burst(input logic g, input int ar_delay, input int nbeats, input bit toggle);
    logic          o;
    logic [DW-1:0] beat;
    int            i, cyc;
    o = ~g;
    @(negedge CLK);
    for (int d = 0; d <= ar_delay; d++) begin
      arready = (d == ar_delay);
      #1;
      chk("arvalid", arvalid, 1'b1);
      chk("gnt", gnt, g);
      chk("araddr", araddr, s_araddr[g]);
      chk("arlen", arlen, s_arlen[g]);
      chk("s_arready", s_arready, (d == ar_delay) ? (g ? 2'b10 : 2'b01) : 2'b00);
      @(posedge CLK);
      @(negedge CLK);
    end
    arready = 1'b0;
    s_arvalid[g] = 1'b0;
    i = 0;
    cyc = 0;
    while (i < nbeats && cyc < 16 * nbeats + 32) begin
      beat = $urandom;
      rvalid = ($urandom_range(0, 3) != 0);
      rdata = beat;
      rlast = (i == nbeats - 1);
      s_rready[g] = toggle ? (cyc % 2 == 0) : 1'b1;
      s_rready[o] = 1'($urandom);
      #1;
      chk("busy_data", busy, 1'b1);
      chk("rready", rready, s_rready[g]);
      chk("s_rvalid_g", s_rvalid[g], rvalid);
      chk("s_rvalid_other", s_rvalid[o], 1'b0);
      chk("s_rdata_other", s_rdata[o], '0);
      if (rvalid) begin
        chk("s_rdata_g", s_rdata[g], beat);
        chk("s_rlast_g", s_rlast[g], rlast);
      end
      if (rvalid && s_rready[g]) i++;
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end
    chk("beats_done", i, nbeats);
    rvalid = 1'b0;
    rlast = 1'b0;
    s_rready = '0;
    m_last = g;
    if (nbeats != s_arlen[g] + 1) m_perr = 1'b1;
    #1;
    chk("busy_end", busy, 1'b0);
    chk("proterr", proterr, m_perr);
  endtask

  initial begin
    logic       g, g2;
    logic [1:0] mask, rem;
    int         nb;
    s_araddr[0] = 32'h1000_0000; s_arlen[0] = 8'd3;
    s_araddr[1] = 32'h2000_0040; s_arlen[1] = 8'd7;

    // Asynchronous reset state
    #2;
    all_quiet("reset");
    chk("reset_proterr", proterr, 1'b0);
    @(negedge CLK);
    ARST = 1'b0;
    #1;

    // S0 alone, 4 beats, immediate ARREADY
    request(2'b01, g);
    chk("t1_gnt_s0", g, 1'b0);
    burst(g, 0, 4, 1'b0);

    // S1 ARLEN=7 with its RREADY toggling
    request(2'b10, g);
    burst(g, 0, 8, 1'b1);

    // Simultaneous requests, ARLEN=0 each, three rounds
    s_arlen[0] = 8'd0; s_arlen[1] = 8'd0;
    for (int r = 0; r < 3; r++) begin
      request(2'b11, g);
      chk("rr_first", g, 1'b0);
      burst(g, 0, 1, 1'b0);
      request(s_arvalid, g);
      chk("rr_second", g, 1'b1);
      burst(g, 0, 1, 1'b0);
    end

    // ARREADY held low for 5 cycles
    s_arlen[0] = 8'd1;
    request(2'b01, g);
    burst(g, 5, 2, 1'b0);

    // ARLEN=3 but RLAST on the third beat
    s_arlen[0] = 8'd3;
    request(2'b01, g);
    burst(g, 0, 3, 1'b0);
    chk("early_rlast_perr", proterr, 1'b1);
    RSTS = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSTS = 1'b0;
    m_perr = 1'b0;
    m_last = 1'b1;
    #1;
    chk("rsts_clears_perr", proterr, 1'b0);

    // Complete S0 so S1 would be favoured, then abort an S0 burst with ARST
    request(2'b01, g);
    burst(g, 0, 4, 1'b0);
    request(2'b01, g);
    @(negedge CLK);
    arready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hdead_beef;
    s_rready = 2'b11;
    #1;
    chk("pre_arst_rvalid", s0_rvalid, 1'b1);
    #1;
    ARST = 1'b1;
    #1;
    all_quiet("arst_mid");
    chk("arst_proterr", proterr, 1'b0);
    rvalid = 1'b0;
    s_rready = 2'b00;
    s_arvalid = 2'b00;
    @(negedge CLK);
    ARST = 1'b0;
    m_last = 1'b1;
    m_perr = 1'b0;
    #1;
    request(2'b11, g);
    chk("arst_ptr_s0", g, 1'b0);
    burst(g, 0, 4, 1'b0);
    request(s_arvalid, g);
    burst(g, 0, 1, 1'b0);

    // Randomized bursts
    for (int n = 0; n < 24; n++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        s_araddr[k] = $urandom;
        s_arlen[k] = 8'($urandom_range(0, 15));
      end
      request(mask, g);
      nb = s_arlen[g] + 1;
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, s_arlen[g] + 2);
      burst(g, $urandom_range(0, 3), nb, 1'($urandom));
      rem = mask;
      rem[g] = 1'b0;
      if (rem != 2'b00) begin
        request(rem, g2);
        burst(g2, $urandom_range(0, 3), s_arlen[g2] + 1, 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flt_rdarb.md
Name: flt_rdarb

Overview:
- Two-requester arbiter for the filter's single AXI read port (M_AXI_AR*/R*).
- Requester 0 is the VRAM source-fetch path of the filter VRAM controller. Requester 1 is a secondary reader, such as a coefficient/LUT loader.
- Grants one burst at a time with round-robin priority, then routes R beats back to the granted requester until RLAST.
- Sits between the requesters and the top-level M_AXI read channel. Fixed AR fields (ID, SIZE, BURST, etc.) stay tied off at the top level.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width.

Ports:
- CLK  in  1  system clock.
- ARST  in  1  asynchronous reset, active-high.
- RSTS  in  1  synchronous soft reset from the register block.
- S0_ARADDR  in  ADDR_WIDTH  requester 0 burst address.
- S0_ARLEN  in  8  requester 0 burst length minus 1.
- S0_ARVALID  in  1  requester 0 address valid.
- S0_ARREADY  out  1  requester 0 address accepted.
- S0_RDATA  out  DATA_WIDTH  read data to requester 0.
- S0_RLAST  out  1  last beat to requester 0.
- S0_RVALID  out  1  beat valid to requester 0.
- S0_RREADY  in  1  requester 0 accepts beat.
- S1_*  same seven signals for requester 1.
- ARADDR  out  ADDR_WIDTH  to M_AXI_ARADDR.
- ARLEN  out  8  to M_AXI_ARLEN.
- ARVALID  out  1  to M_AXI_ARVALID.
- ARREADY  in  1  from M_AXI_ARREADY.
- RDATA  in  DATA_WIDTH  from M_AXI_RDATA.
- RLAST  in  1  from M_AXI_RLAST.
- RVALID  in  1  from M_AXI_RVALID.
- RREADY  out  1  to M_AXI_RREADY.
- GNT  out  1  current/last granted requester (0/1).
- BUSY  out  1  high whenever the state is not IDLE.
- PROTERR  out  1  sticky: burst beat count did not match the latched ARLEN.

Behaviour:
- Reset (ARST, asynchronous):
  - State IDLE. Priority pointer favours S0. GNT=0, PROTERR=0, beat counter 0.
  - All outputs deasserted: ARVALID, RREADY, S*_ARREADY, S*_RVALID, S*_RLAST = 0. Data outputs = 0.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If RSTS=1: clear PROTERR, set pointer to S0, grant nothing.
  - Otherwise, if any S*_ARVALID: pick a requester by pointer. If both request, the one not served last wins. If only one requests, it wins.
  - Register GNT and the selected ARLEN. Go to ADDR next cycle.
  - A request seen in IDLE produces ARVALID exactly 1 cycle later.
- ADDR:
  - ARVALID=1. ARADDR/ARLEN are muxed combinationally from the granted requester, which must hold them stable per AXI.
  - Granted S_ARREADY = ARREADY; the non-granted S_ARREADY = 0.
  - On ARVALID&ARREADY: go to DATA and clear the beat counter.
  - ARVALID is never withdrawn before ARREADY.
- DATA:
  - Granted S_RVALID=RVALID, S_RDATA=RDATA, S_RLAST=RLAST, and RREADY=granted S_RREADY.
  - Non-granted S_RVALID=0 and its data is held at 0.
  - Each RVALID&RREADY increments the 9-bit beat counter.
  - On the handshake with RLAST=1:
    - Go to IDLE and flip the pointer away from GNT.
    - Set PROTERR if count+1 != ARLEN+1.
  - A handshake without RLAST once count+1 == ARLEN+1 also sets PROTERR. Still wait for RLAST.
- RSTS in ADDR/DATA is ignored, so an AXI transaction is never abandoned. It takes effect once back in IDLE.
- The pointer updates only on burst completion. Simultaneous new requests during DATA wait for IDLE, so the idle gap between bursts is 1 cycle.
- A requester dropping ARVALID while in IDLE is legal. Dropping it in ADDR is a requester protocol violation and is not checked.
- Throughput is one outstanding burst. Beats pass through combinationally with zero added latency.

Decomposition:
- Shared package flt_rdarb_pkg:
  - state enum IDLE/ADDR/DATA.
  - GNT_S0/GNT_S1 constants.
  - beat-counter width 9.
- One sub-module, flt_rdarb_rrsel: the combinational 2-way round-robin pick from {ARVALID[1:0], pointer}. Everything else lives in flt_rdarb.

Test Plan:
- S0 alone, ARADDR=0x1000_0000, ARLEN=3, ARREADY immediate:
  - ARVALID rises 1 cycle after S0_ARVALID.
  - 4 beats reach S0 only, S1_RVALID stays 0.
  - BUSY falls after RLAST; PROTERR=0.
- S0 and S1 request in the same cycle, each ARLEN=0, repeated three times:
  - Grants go S0, S1, S0, S1, S0, S1.
  - GNT matches each burst; there is a 1-cycle IDLE gap between bursts.
- ARREADY held low for 5 cycles:
  - ARVALID and ARADDR stay stable.
  - S0_ARREADY pulses only in the cycle ARREADY=1.
- S1 burst ARLEN=7 with S1_RREADY toggling every other cycle:
  - RREADY mirrors S1_RREADY.
  - All 8 data words arrive in order.
- ARLEN=3 but RLAST on beat 2 -> PROTERR=1 and state IDLE. A later RSTS pulse in IDLE clears PROTERR to 0.
- ARST asserted mid-DATA -> all outputs 0 and BUSY=0 immediately (asynchronously). Pointer favours S0 after release.
